mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch path and its load/store path. Each requester uses a req/ack handshake. The block grants one requester at a time, round-robin, and registers the memory-side request. For data accesses it generates byte enables and write-data lane replication from funct3 and the address, and it sign- or zero-extends load data. A wait-cycle watchdog converts a hung memory access into an error response.

Parameters:
MAX_WAIT, 15, memory cycles (m_req high, no m_ack) tolerated before a timeout error; valid range 1..255.

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; held with if_addr until if_ack.
if_addr  in  32  fetch word address.
if_rdata  out  32  fetched instruction; valid while if_ack=1.
if_ack  out  1  one-cycle completion pulse for fetch.
d_req  in  1  load/store request; held with the other d_* fields until d_ack.
d_we  in  1  1 = store, 0 = load.
d_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
d_addr  in  32  byte address.
d_wdata  in  32  store data, right-aligned.
d_rdata  out  32  extended load data; valid while d_ack=1.
d_ack  out  1  one-cycle completion pulse for data.
d_err  out  1  misalign or timeout; valid only with d_ack.
if_err  out  1  timeout on fetch; valid only with if_ack.
m_req  out  1  memory request, registered.
m_we  out  1  memory write enable.
m_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
m_be  out  4  byte enables.
m_wdata  out  32  lane-replicated write data.
m_rdata  in  32  memory read data; valid with m_ack.
m_ack  in  1  memory completion pulse.

Behaviour:
- Reset (sync, any state): state=IDLE; last_grant=DATA (so fetch wins the first tie); wait_cnt=0. All outputs 0 in the cycle after rst is sampled. An m_ack arriving after reset is ignored.
- FSM states: IDLE, GRANT_IF, GRANT_D, RESP.
- IDLE, no requests: stay in IDLE.
- IDLE, one req high: grant it.
- IDLE, both reqs high: grant the requester not in last_grant, then update last_grant.
- On grant: latch addr/we/be/wdata/funct3. m_req=1 from the next cycle.
- GRANT_*: m_req held high with stable fields. wait_cnt increments each cycle.
- GRANT_*, on m_ack=1: capture m_rdata, go to RESP.
- GRANT_*, when wait_cnt reaches MAX_WAIT with no m_ack: drop m_req, set err, rdata=0, go to RESP.
- RESP: exactly one cycle. Granted *_ack=1, with *_rdata and *_err. No new grant is made in RESP, so a requester dropping req after the ack is never re-served. RESP→IDLE.
- Latency: request sampled in IDLE at cycle N; m_req high N+1..; m_ack at cycle M → *_ack at M+1. Minimum 3 cycles per transaction (zero-wait memory acks at N+1, *_ack at N+2).
- Misaligned data access (H/HU with addr[0]=1; W with addr[1:0]≠0): no memory access. Go GRANT_D→RESP the next cycle with d_err=1, d_rdata=0.
- Byte enables (stores and loads):
  - B/BU: m_be = 4'b0001 << addr[1:0]; m_wdata = {4{wdata[7:0]}}.
  - H/HU: m_be = addr[1] ? 1100 : 0011; m_wdata = {2{wdata[15:0]}}.
  - W: m_be = 1111; m_wdata = wdata.
- Fetches always use m_we=0, m_be=1111.
- Load extraction: select the byte or half lane by addr[1:0]. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- Undefined funct3 (011, 110, 111): treated as W.
- A req dropped mid-transaction is ignored; the transaction completes and ack still pulses.
- m_ack outside GRANT_* is ignored.

Decomposition:
- Shared defs header: FSM state encodings; funct3 width codes (FUNCT3_B/H/W/BU/HU); GRANT_IF/GRANT_D codes.
- One sub-module: mem_lane_align. Combinational; computes be/wdata replication, load extension and the misalign flag from funct3, addr[1:0] and data. Reused later by the pipelined core.

Test Plan:
- Fetch only, zero-wait memory: if_req, if_addr=0x40 at cycle 0; m_ack at cycle 1 with m_rdata=0x00500093 → m_req cycle 1, m_addr=0x40, m_be=1111; if_ack cycle 2, if_rdata=0x00500093.
- Contention after reset: if_req and d_req both high at cycle 0 → fetch served first. d granted in the IDLE after RESP. Two completions with alternating grants while both reqs are held.
- Store byte: d_we=1, funct3=000, addr=0x103, wdata=0xAB → m_addr=0x100, m_be=1000, m_wdata=0xABABABAB.
- Load sign/zero extension: addr=0x102, m_rdata=0x80FF1234. funct3=001 → d_rdata=0xFFFF80FF; funct3=101 → 0x000080FF; funct3=100 at addr=0x101 → 0x00000012.
- Misalign and timeout: LW at addr=0x102 → no m_req, d_ack+d_err one cycle after grant. Fetch with memory never acking, MAX_WAIT=15 → m_req high exactly 15 cycles, then if_ack+if_err, if_rdata=0.
- Reset mid-operation: rst asserted during GRANT_D with m_req=1 → m_req=0 next cycle, no ack pulse; a late m_ack is ignored; the next if_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter:
// FSM state codes, grant codes and RV32I load/store width codes.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT_IF = 2'd1;
    localparam logic [1:0] ST_GRANT_D  = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for RV32I loads/stores (combinational).
// Ports: funct3, addr_lo (addr[1:0]), wdata (right-aligned store data),
//        rdata (raw memory word) -> be, wdata_rep (lane-replicated),
//        rdata_ext (extracted and extended load), misalign.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [31:0] shifted;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    // Undefined width codes fall through to word handling.
    assign is_b    = funct3[1:0] == FUNCT3_B[1:0];
    assign is_h    = funct3[1:0] == FUNCT3_H[1:0];
    assign sext    = ~funct3[2];
    assign shifted = rdata >> {addr_lo, 3'b000};
    assign b_lane  = shifted[7:0];
    assign h_lane  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = 1'b0;
        unique case (1'b1)
            is_b: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & b_lane[7]}}, b_lane};
            end
            is_h: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & h_lane[15]}}, h_lane};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign = addr_lo != 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Ports: if_* fetch req/ack, d_* data req/ack, m_* registered memory side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        if_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic        gnt;
    logic        last_gnt;
    logic [7:0]  wait_cnt;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        idle;
    logic        pick_if;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic [31:0] al_rd;
    logic        al_mis;

    assign idle    = state == ST_IDLE;
    assign pick_if = if_req & (~d_req | (last_gnt == GNT_D));

    // In IDLE the aligner looks at the live request so misalignment
    // is known at grant time; afterwards it works on latched fields.
    assign al_f3 = idle ? d_funct3 : f3_q;
    assign al_lo = idle ? d_addr[1:0] : addr_q[1:0];

    mem_lane_align u_align (
        .funct3   (al_f3),
        .addr_lo  (al_lo),
        .wdata    (wdata_q),
        .rdata    (m_rdata),
        .be       (al_be),
        .wdata_rep(al_wd),
        .rdata_ext(al_rd),
        .misalign (al_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= GNT_IF;
            last_gnt <= GNT_D;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req | d_req) begin
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
                        rdata_q  <= '0;
                        if (pick_if) begin
                            gnt      <= GNT_IF;
                            last_gnt <= GNT_IF;
                            addr_q   <= if_addr;
                            we_q     <= 1'b0;
                            f3_q     <= FUNCT3_W;
                            wdata_q  <= '0;
                            req_q    <= 1'b1;
                            state    <= ST_GRANT_IF;
                        end else begin
                            gnt      <= GNT_D;
                            last_gnt <= GNT_D;
                            addr_q   <= d_addr;
                            we_q     <= d_we;
                            f3_q     <= d_funct3;
                            wdata_q  <= d_wdata;
                            req_q    <= ~al_mis;
                            state    <= ST_GRANT_D;
                        end
                    end
                end
                ST_GRANT_IF, ST_GRANT_D: begin
                    if (!req_q) begin
                        // misaligned data access: never reached memory
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else if (m_ack) begin
                        req_q   <= 1'b0;
                        rdata_q <= (gnt == GNT_IF) ? m_rdata : al_rd;
                        state   <= ST_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack   = (state == ST_RESP) & (gnt == GNT_IF);
    assign d_ack    = (state == ST_RESP) & (gnt == GNT_D);
    assign if_rdata = if_ack ? rdata_q : '0;
    assign d_rdata  = d_ack ? rdata_q : '0;
    assign if_err   = if_ack & err_q;
    assign d_err    = d_ack & err_q;

    assign m_req   = req_q;
    assign m_we    = req_q & we_q;
    assign m_addr  = req_q ? {addr_q[31:2], 2'b00} : '0;
    assign m_be    = !req_q ? 4'h0 : ((gnt == GNT_IF) ? 4'hF : al_be);
    assign m_wdata = (req_q & (gnt == GNT_D)) ? al_wd : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        if_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          mcnt;
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic        gi;
        logic        gd;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic        unst;
        logic        hung;
    } obs_t;

    mem_port_arbiter #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .if_err(if_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_be(m_be), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives the memory side for one transaction: acks after wt extra
    // wait cycles (wt < 0: never), drops the served req at its ack.
    task automatic run_txn(input int wt, input logic [31:0] rd,
                           output obs_t o);
        o = '{default: '0};
        o.hung = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            o.cyc++;
            m_ack = 1'b0;
            if (if_ack || d_ack) begin
                o.gi    = if_ack;
                o.gd    = d_ack;
                o.rdata = if_ack ? if_rdata : d_rdata;
                o.err   = if_ack ? if_err : d_err;
                if (if_ack) if_req = 1'b0;
                if (d_ack) d_req = 1'b0;
                o.hung = 1'b0;
                break;
            end
            if (m_req) begin
                if (o.mcnt == 0) begin
                    o.a  = m_addr;
                    o.be = m_be;
                    o.we = m_we;
                    o.wd = m_wdata;
                end else if ({m_addr, m_be, m_we, m_wdata} !==
                             {o.a, o.be, o.we, o.wd}) begin
                    o.unst = 1'b1;
                end
                o.mcnt++;
                if (wt >= 0 && o.mcnt == wt + 1) begin
                    m_ack   = 1'b1;
                    m_rdata = rd;
                end
            end
        end
        m_ack = 1'b0;
    endtask

    // Reference rules, written in terms of access size in bytes.
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input logic [2:0] f3,
                                   input logic [31:0] addr);
        int n = nbytes(f3);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3,
                                          input logic [31:0] addr);
        int n = nbytes(f3);
        logic [3:0] m = 4'((1 << n) - 1);
        return m << lane_of(f3, addr);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3,
                                           input logic [31:0] wd);
        int n = nbytes(f3);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] rd);
        int n = nbytes(f3);
        logic [31:0] v;
        logic [31:0] mask;
        if (n == 4) return rd;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = (rd >> (8 * lane_of(f3, addr))) & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3,
                                     input logic [31:0] addr);
        return (addr % nbytes(f3)) != 0;
    endfunction

    task automatic test_reset;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_funct3 = 0; d_addr = 0; d_wdata = 0;
        m_rdata = 0; m_ack = 0;
        do_reset();
        n_tests++;
        if ({if_rdata, if_ack, d_rdata, d_ack, d_err, if_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got %h want 0",
                     {if_rdata, if_ack, d_rdata, d_ack, d_err, if_err});
        end
        n_tests++;
        if ({m_req, m_we, m_addr, m_be, m_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h want 0",
                     {m_req, m_we, m_addr, m_be, m_wdata});
        end
        tick();
        n_tests++;
        if (m_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_mreq: got %b want 0", m_req);
        end
    endtask

    task automatic test_contention;
        obs_t o;
        logic want_if;
        do_reset();
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h200;
        want_if = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 32'h1000 + k, o);
            n_tests++;
            if (o.hung || o.gi !== want_if || o.gd !== !want_if) begin
                n_fail++;
                $display("FAIL contention_%0d: got if=%b d=%b want if=%b",
                         k, o.gi, o.gd, want_if);
            end
            if_req = 1; d_req = 1;
            want_if = !want_if;
        end
        if_req = 0; d_req = 0;
        tick();
        tick();
    endtask

    task automatic test_fetch_zero_wait;
        obs_t o;
        if_req = 1; if_addr = 32'h40;
        run_txn(0, 32'h00500093, o);
        n_tests++;
        if (o.hung || !o.gi || o.rdata !== 32'h00500093 || o.err) begin
            n_fail++;
            $display("FAIL fetch_resp: got %h err=%b want 00500093",
                     o.rdata, o.err);
        end
        n_tests++;
        if (o.a !== 32'h40 || o.be !== 4'hF || o.we !== 0 ||
            o.mcnt != 1) begin
            n_fail++;
            $display("FAIL fetch_mem: got a=%h be=%h we=%b n=%0d",
                     o.a, o.be, o.we, o.mcnt);
        end
        n_tests++;
        if (o.cyc != 2) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d want 2", o.cyc);
        end
        tick();
    endtask

    task automatic test_store_byte;
        obs_t o;
        d_req = 1; d_we = 1; d_funct3 = 3'b000;
        d_addr = 32'h103; d_wdata = 32'hAB;
        run_txn(1, 32'h0, o);
        n_tests++;
        if (o.hung || o.a !== 32'h100 || o.be !== 4'b1000 ||
            o.wd !== 32'hABABABAB || o.we !== 1 || o.err) begin
            n_fail++;
            $display("FAIL store_byte: got a=%h be=%b wd=%h we=%b",
                     o.a, o.be, o.wd, o.we);
        end
        tick();
    endtask

    task automatic test_load_ext;
        obs_t o;
        logic [2:0]  f3s [3];
        logic [31:0] adr [3];
        logic [31:0] exp [3];
        f3s = '{3'b001, 3'b101, 3'b100};
        adr = '{32'h102, 32'h102, 32'h101};
        exp = '{32'hFFFF80FF, 32'h000080FF, 32'h00000012};
        for (int k = 0; k < 3; k++) begin
            d_req = 1; d_we = 0; d_funct3 = f3s[k]; d_addr = adr[k];
            run_txn(k, 32'h80FF1234, o);
            n_tests++;
            if (o.hung || !o.gd || o.rdata !== exp[k] || o.err) begin
                n_fail++;
                $display("FAIL load_ext_%0d: got %h want %h",
                         k, o.rdata, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_misalign;
        obs_t o;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h102;
        run_txn(0, 32'hDEADBEEF, o);
        n_tests++;
        if (o.hung || !o.gd || !o.err || o.rdata !== 0 ||
            o.mcnt != 0 || o.cyc != 2) begin
            n_fail++;
            $display("FAIL misalign: got err=%b rd=%h n=%0d cyc=%0d",
                     o.err, o.rdata, o.mcnt, o.cyc);
        end
        tick();
    endtask

    task automatic test_timeout;
        obs_t o;
        if_req = 1; if_addr = 32'h500;
        run_txn(-1, 32'h0, o);
        n_tests++;
        if (o.hung || !o.gi || !o.err || o.rdata !== 0) begin
            n_fail++;
            $display("FAIL timeout_resp: got err=%b rd=%h", o.err, o.rdata);
        end
        n_tests++;
        if (o.mcnt != 15 || o.unst) begin
            n_fail++;
            $display("FAIL timeout_mreq_cycles: got %0d want 15", o.mcnt);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        obs_t o;
        logic seen;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h300;
        tick();
        n_tests++;
        if (m_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got m_req=%b want 1", m_req);
        end
        rst = 1;
        tick();
        rst = 0; d_req = 0;
        n_tests++;
        if (m_req !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got m_req=%b d_ack=%b",
                     m_req, d_ack);
        end
        m_ack = 1; m_rdata = 32'h12345678;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            m_ack = 0;
            seen = seen | d_ack | if_ack | m_req;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_late_ack: got activity=%b want 0", seen);
        end
        if_req = 1; if_addr = 32'h44;
        run_txn(2, 32'hCAFEF00D, o);
        n_tests++;
        if (o.hung || !o.gi || o.rdata !== 32'hCAFEF00D || o.err ||
            o.a !== 32'h44) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h want cafef00d", o.rdata);
        end
        tick();
    endtask

    task automatic test_random;
        obs_t o;
        logic        last_if;
        logic        exp_if;
        logic [31:0] ifa;
        logic [31:0] rd;
        logic [31:0] want;
        int          mode;
        int          wt;
        int          nt;
        do_reset();
        last_if = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mode = int'($urandom_range(0, 2));
            ifa = $urandom;
            if (mode != 1) begin
                if_req = 1; if_addr = ifa;
            end
            if (mode != 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_funct3 = 3'($urandom_range(0, 7));
                d_addr = $urandom; d_wdata = $urandom;
            end
            nt = (mode == 2) ? 2 : 1;
            for (int t = 0; t < nt; t++) begin
                exp_if = if_req && (!d_req || !last_if);
                wt = ($urandom_range(0, 7) == 0) ? -1
                     : int'($urandom_range(0, 3));
                rd = $urandom;
                run_txn(wt, rd, o);
                last_if = exp_if;
                n_tests++;
                if (o.hung || o.gi !== exp_if || o.gd !== !exp_if ||
                    o.unst) begin
                    n_fail++;
                    $display("FAIL rnd_grant_%0d: got if=%b d=%b want if=%b",
                             k, o.gi, o.gd, exp_if);
                end
                if (exp_if) begin
                    want = (wt < 0) ? 32'h0 : rd;
                    n_tests++;
                    if (o.a !== {ifa[31:2], 2'b00} || o.be !== 4'hF ||
                        o.rdata !== want || o.err !== (wt < 0) ||
                        o.mcnt != ((wt < 0) ? 15 : wt + 1)) begin
                        n_fail++;
                        $display("FAIL rnd_fetch_%0d: got a=%h rd=%h want %h",
                                 k, o.a, o.rdata, want);
                    end
                end else if (exp_mis(d_funct3, d_addr)) begin
                    n_tests++;
                    if (o.mcnt != 0 || !o.err || o.rdata !== 0) begin
                        n_fail++;
                        $display("FAIL rnd_misalign_%0d: got n=%0d err=%b",
                                 k, o.mcnt, o.err);
                    end
                end else begin
                    n_tests++;
                    if (o.a !== {d_addr[31:2], 2'b00} ||
                        o.be !== exp_be(d_funct3, d_addr) ||
                        o.we !== d_we || o.err !== (wt < 0) ||
                        o.mcnt != ((wt < 0) ? 15 : wt + 1) ||
                        (d_we && o.wd !== exp_wd(d_funct3, d_wdata))) begin
                        n_fail++;
                        $display("FAIL rnd_data_%0d: got a=%h be=%b wd=%h",
                                 k, o.a, o.be, o.wd);
                    end
                    if (!d_we) begin
                        want = (wt < 0) ? 32'h0
                               : exp_ld(d_funct3, d_addr, rd);
                        n_tests++;
                        if (o.rdata !== want) begin
                            n_fail++;
                            $display("FAIL rnd_load_%0d: got %h want %h",
                                     k, o.rdata, want);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_contention();
        test_fetch_zero_wait();
        test_store_byte();
        test_load_ext();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
